mac_lane_tree: RTL and testbench

Upstream stage of the INT8 vector MAC. It takes one beat of up to 16 unsigned 8-bit operand pairs per cycle and multiplies the active lanes element-wise. It reduces the products through a pipelined adder tree and emits one 20-bit `partial_sum` per beat into `accumulator_var`. It tracks element position within the ELEMS-long vector, so the final beat masks lanes beyond ELEMS. Its beat count per vector matches the accumulator's `beats_max` exactly.

---
 rtl/mac_pkg.sv | 21 ++
 rtl/mac_adder_tree.sv | 108 ++++++++++
 rtl/mac_lane_tree.sv | 105 ++++++++++
 tb/tb_mac_lane_tree.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths and lane helpers for the INT8 vector MAC
package mac_pkg;
  localparam int W_LANE    = 8;
  localparam int MAX_LANES = 16;
  localparam int W_PROD    = 16;
  localparam int W_PSUM    = 20;

  localparam logic [4:0] LANES_DEF = 5'd4;

  // Only power-of-two lane counts up to 16 are legal; anything else falls back to 4.
  function automatic logic [4:0] norm_lanes(input logic [4:0] lanes);
    case (lanes)
      5'd1, 5'd2, 5'd4, 5'd8, 5'd16: return lanes;
      default:                       return LANES_DEF;
    endcase
  endfunction

  function automatic int beats_per_vec(input int elems, input int lanes);
    return (elems + lanes - 1) / lanes;
  endfunction
endpackage

// File: rtl/mac_adder_tree.sv
// rtl/mac_adder_tree.sv - 16-input product reduction tree with output register
// MAC_TREE_PIPE_EN adds a register after the 4-way partial sums (one extra cycle).
module mac_adder_tree
  import mac_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [4:0]                  in_lanes,
  input  logic [MAX_LANES*W_PROD-1:0] prod,
  output logic                        out_valid,
  output logic [4:0]                  out_lanes,
  output logic [W_PSUM-1:0]           sum
);
  localparam int W_L1 = W_PROD + 1;
  localparam int W_L2 = W_PROD + 2;
  localparam int W_L3 = W_PROD + 3;

  logic [W_L1-1:0]   l1   [8];
  logic [W_L2-1:0]   l2   [4];
  logic [W_L2-1:0]   l2_t [4];
  logic [W_L3-1:0]   l3   [2];
  logic              v_t;
  logic [4:0]        lanes_t;
  logic [W_PSUM-1:0] sum_d, sum_q;
  logic              valid_d, valid_q;
  logic [4:0]        lanes_d, lanes_q;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      l1[i] = {1'b0, prod[2*i*W_PROD +: W_PROD]} + {1'b0, prod[(2*i+1)*W_PROD +: W_PROD]};
    end
    for (int i = 0; i < 4; i++) begin
      l2[i] = {1'b0, l1[2*i]} + {1'b0, l1[2*i+1]};
    end
  end

`ifdef MAC_TREE_PIPE_EN
  logic [W_L2-1:0] l2_d [4];
  logic [W_L2-1:0] l2_q [4];
  logic            v_p_d, v_p_q;
  logic [4:0]      lanes_p_d, lanes_p_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      l2_d[i] = l2[i];
    end
    v_p_d     = in_valid;
    lanes_p_d = in_lanes;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        l2_q[i] <= '0;
      end
      v_p_q     <= 1'b0;
      lanes_p_q <= LANES_DEF;
    end else begin
      for (int i = 0; i < 4; i++) begin
        l2_q[i] <= l2_d[i];
      end
      v_p_q     <= v_p_d;
      lanes_p_q <= lanes_p_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      l2_t[i] = l2_q[i];
    end
    v_t     = v_p_q;
    lanes_t = lanes_p_q;
  end
`else
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      l2_t[i] = l2[i];
    end
    v_t     = in_valid;
    lanes_t = in_lanes;
  end
`endif

  always_comb begin
    l3[0]   = {1'b0, l2_t[0]} + {1'b0, l2_t[1]};
    l3[1]   = {1'b0, l2_t[2]} + {1'b0, l2_t[3]};
    sum_d   = {1'b0, l3[0]} + {1'b0, l3[1]};
    valid_d = v_t;
    lanes_d = lanes_t;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
      lanes_q <= LANES_DEF;
    end else begin
      sum_q   <= sum_d;
      valid_q <= valid_d;
      lanes_q <= lanes_d;
    end
  end

  assign sum       = sum_q;
  assign out_valid = valid_q;
  assign out_lanes = lanes_q;
endmodule

// File: rtl/mac_lane_tree.sv
// rtl/mac_lane_tree.sv - lane-masked INT8 multiply and reduce, one partial sum per beat
// Latency 3, or 4 when MAC_TREE_PIPE_EN is defined.
module mac_lane_tree
  import mac_pkg::*;
#(
  parameter int ELEMS     = 1000,
  parameter int MAX_LANES = 16,
  parameter int W_IN      = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [MAX_LANES*W_LANE-1:0] a_vec,
  input  logic [MAX_LANES*W_LANE-1:0] b_vec,
  input  logic [4:0]                 lanes_i,
  output logic                       out_valid,
  output logic [W_IN-1:0]            partial_sum,
  output logic [4:0]                 lanes_o
);
  localparam int CW = $clog2(ELEMS) + 1;

  logic [CW-1:0] elem_cnt_d, elem_cnt_q;
  logic [4:0]    lanes_d, lanes_q;
  logic [4:0]    lanes_cur;
  logic [CW-1:0] rem, live;
  logic          last_beat;

  logic [MAX_LANES*W_LANE-1:0] a_s1_d, a_s1_q, b_s1_d, b_s1_q;
  logic                        v_s1_d, v_s1_q;
  logic [4:0]                  lanes_s1_d, lanes_s1_q;

  logic [MAX_LANES*W_PROD-1:0] prod_s2_d, prod_s2_q;
  logic                        v_s2_d, v_s2_q;
  logic [4:0]                  lanes_s2_d, lanes_s2_q;

  // The first beat of a vector uses the freshly sampled lane count directly.
  always_comb begin
    lanes_cur  = (elem_cnt_q == '0) ? norm_lanes(lanes_i) : lanes_q;
    rem        = CW'(ELEMS) - elem_cnt_q;
    last_beat  = (rem <= CW'(lanes_cur));
    live       = last_beat ? rem : CW'(lanes_cur);
    elem_cnt_d = elem_cnt_q;
    lanes_d    = lanes_q;
    if (in_valid) begin
      lanes_d    = lanes_cur;
      elem_cnt_d = last_beat ? '0 : elem_cnt_q + CW'(lanes_cur);
    end
    for (int k = 0; k < MAX_LANES; k++) begin
      if (CW'(k) < live) begin
        a_s1_d[k*W_LANE +: W_LANE] = a_vec[k*W_LANE +: W_LANE];
        b_s1_d[k*W_LANE +: W_LANE] = b_vec[k*W_LANE +: W_LANE];
      end else begin
        a_s1_d[k*W_LANE +: W_LANE] = '0;
        b_s1_d[k*W_LANE +: W_LANE] = '0;
      end
    end
    v_s1_d     = in_valid;
    lanes_s1_d = lanes_cur;
  end

  always_comb begin
    prod_s2_d = '0;
    for (int k = 0; k < MAX_LANES; k++) begin
      prod_s2_d[k*W_PROD +: W_PROD] = W_PROD'(a_s1_q[k*W_LANE +: W_LANE])
                                    * W_PROD'(b_s1_q[k*W_LANE +: W_LANE]);
    end
    v_s2_d     = v_s1_q;
    lanes_s2_d = lanes_s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_cnt_q <= '0;
      lanes_q    <= LANES_DEF;
      a_s1_q     <= '0;
      b_s1_q     <= '0;
      v_s1_q     <= 1'b0;
      lanes_s1_q <= LANES_DEF;
      prod_s2_q  <= '0;
      v_s2_q     <= 1'b0;
      lanes_s2_q <= LANES_DEF;
    end else begin
      elem_cnt_q <= elem_cnt_d;
      lanes_q    <= lanes_d;
      a_s1_q     <= a_s1_d;
      b_s1_q     <= b_s1_d;
      v_s1_q     <= v_s1_d;
      lanes_s1_q <= lanes_s1_d;
      prod_s2_q  <= prod_s2_d;
      v_s2_q     <= v_s2_d;
      lanes_s2_q <= lanes_s2_d;
    end
  end

  mac_adder_tree u_tree (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v_s2_q),
    .in_lanes  (lanes_s2_q),
    .prod      (prod_s2_q),
    .out_valid (out_valid),
    .out_lanes (lanes_o),
    .sum       (partial_sum)
  );
endmodule

// File: tb/tb_mac_lane_tree.sv
// tb/tb_mac_lane_tree.sv - scoreboard bench for mac_lane_tree (honours MAC_TREE_PIPE_EN)
module tb_mac_lane_tree;
`ifdef MAC_TREE_PIPE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] a_vec = '0;
  logic [127:0] b_vec = '0;
  logic [4:0]   lanes_i = 5'd16;
  logic         out_valid;
  logic [19:0]  partial_sum;
  logic [4:0]   lanes_o;

  mac_lane_tree #(.ELEMS(1000), .MAX_LANES(16), .W_IN(20)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .a_vec       (a_vec),
    .b_vec       (b_vec),
    .lanes_i     (lanes_i),
    .out_valid   (out_valid),
    .partial_sum (partial_sum),
    .lanes_o     (lanes_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] sum;
    logic [4:0]  lanes;
    int          cyc;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           cyc = 0;
  int           tests = 0;
  int           fails = 0;
  int           got_beats = 0;
  int           got_sum = 0;
  logic [127:0] va, vb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("partial_sum", {12'd0, partial_sum}, {12'd0, mon_e.sum});
        check("lanes_o", {27'd0, lanes_o}, {27'd0, mon_e.lanes});
        check("latency", cyc - mon_e.cyc, LAT);
        got_beats++;
        got_sum += int'(partial_sum);
      end
    end
  end

  function automatic logic [127:0] fill(input logic [7:0] v);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [127:0] ramp();
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = 8'(k + 1);
    return r;
  endfunction

  // Called and returns at 1 time unit after a rising edge.
  task automatic send_vector(input logic [4:0] lanes_req, input logic [127:0] a,
                             input logic [127:0] b, input int beats, input int full,
                             input int last, input logic [4:0] exp_lanes,
                             input int sw_beat, input logic [4:0] sw_lanes, input int gap_every);
    exp_t e;
    for (int i = 0; i < beats; i++) begin
      if (gap_every > 0 && (i % gap_every) == gap_every - 1) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      lanes_i  = (sw_beat >= 0 && i >= sw_beat) ? sw_lanes : lanes_req;
      a_vec    = a;
      b_vec    = b;
      in_valid = 1'b1;
      e.sum    = (i == beats - 1) ? 20'(last) : 20'(full);
      e.lanes  = exp_lanes;
      e.cyc    = cyc;
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
  endtask

  task automatic drain_check(input string name, input int beats, input int sum);
    in_valid = 1'b0;
    for (int t = 0; t < LAT + 10 && exp_q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_beats"}, got_beats, beats);
    check({name, "_sum"}, got_sum, sum);
    exp_q.delete();
    got_beats = 0;
    got_sum   = 0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({name, "_partial_sum"}, {12'd0, partial_sum}, 32'd0);
    check({name, "_lanes_o"}, {27'd0, lanes_o}, 32'd4);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    send_vector(5'd16, fill(8'd255), fill(8'd255), 1, 1040400, 1040400, 5'd16, -1, 5'd0, 0);
    drain_check("single_max", 1, 1040400);
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;

    send_vector(5'd16, fill(8'd1), fill(8'd1), 63, 16, 8, 5'd16, -1, 5'd0, 0);
    drain_check("vec16_ones", 63, 1000);

    va = fill(8'd255);
    va[31:0] = {4{8'd2}};
    vb = fill(8'd255);
    vb[31:0] = {4{8'd3}};
    send_vector(5'd4, va, vb, 250, 24, 24, 5'd4, -1, 5'd0, 0);
    drain_check("lanes4_gate", 250, 6000);

    // Lane request switches mid-vector, then a back-to-back 2-lane vector.
    send_vector(5'd16, ramp(), fill(8'd2), 63, 272, 72, 5'd16, 10, 5'd2, 0);
    send_vector(5'd2, ramp(), fill(8'd2), 500, 6, 6, 5'd2, -1, 5'd0, 0);
    drain_check("wrap_16_to_2", 563, 19936);

    send_vector(5'd7, fill(8'd1), fill(8'd1), 250, 4, 4, 5'd4, -1, 5'd0, 0);
    drain_check("illegal7", 250, 1000);

    send_vector(5'd16, fill(8'd1), fill(8'd1), 30, 16, 16, 5'd16, -1, 5'd0, 0);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    got_beats = 0;
    got_sum   = 0;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      check("post_rst_quiet", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    send_vector(5'd8, fill(8'd3), fill(8'd5), 125, 120, 120, 5'd8, -1, 5'd0, 0);
    drain_check("after_reset_l8", 125, 15000);

    va = fill(8'd255);
    va[7:0] = 8'd7;
    vb = fill(8'd255);
    vb[7:0] = 8'd9;
    send_vector(5'd1, va, vb, 1000, 63, 63, 5'd1, -1, 5'd0, 3);
    drain_check("lanes1_gaps", 1000, 63000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end
endmodule
